pmem_req_scheduler: RTL and testbench
=====================================

Name: pmem_req_scheduler

Overview:
- Schedules the single 256-bit line port of the cacheline adaptor among three requesters: I-cache miss path, D-cache miss path, and the instruction stream-buffer prefetcher.
- Sits between the L1 miss interfaces and the cacheline_adaptor line-side port.
- Replaces the ad-hoc OR of prefetch reads and the address mux around the adaptor.
- Provides fixed priority with anti-starvation and exactly-one-owner transactions.

Parameters:
- STARVE_LIMIT, 4: consecutive D grants allowed while I is pending before I is forced to win. Range 1..15.
- PF_ENABLE, 1: 0 ties the prefetch request low internally; pf_resp is then never asserted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_addr  in  32  I-side line address
- i_read  in  1  I-side read request; I never writes
- i_resp  out  1  I transaction done
- d_addr  in  32  D-side line address
- d_wdata  in  256  D writeback line
- d_read  in  1  D read request
- d_write  in  1  D write request
- d_resp  out  1  D transaction done
- pf_addr  in  32  prefetch line address
- pf_read  in  1  prefetch read request
- pf_resp  out  1  prefetch transaction done
- line_rdata  out  256  c_rdata broadcast to all requesters; valid only with the owner's resp
- c_addr  out  32  to adaptor address_i
- c_wdata  out  256  to adaptor line_i
- c_read  out  1  to adaptor read_i
- c_write  out  1  to adaptor write_i
- c_rdata  in  256  from adaptor line_o
- c_resp  in  1  from adaptor resp_o
- owner  out  2  current owner: 0 none, 1 I, 2 D, 3 PF; for perf counters
- busy  out  1  state is not IDLE

Behaviour:
- FSM states: IDLE, OWN_I, OWN_D, OWN_PF, DONE. Every owned transaction runs state -> DONE -> IDLE, so there is at least one idle cycle between transactions and the adaptor sees read/write drop.
- IDLE arbitration picks one owner and moves to its OWN state on the next edge:
  - D wins if d_read or d_write is asserted, unless starve_cnt == STARVE_LIMIT and i_read is asserted; then I wins.
  - Otherwise I wins if i_read is asserted.
  - Otherwise PF wins if pf_read is asserted and PF_ENABLE is 1.
- Requests are sampled in IDLE only. No grant is issued in the same cycle as the request; minimum added latency is 1 cycle.
- starve_cnt (4-bit):
  - Increments when D is granted while i_read is asserted.
  - Clears when I is granted, or when D is granted with i_read low.
  - Saturates at STARVE_LIMIT.
- In OWN_x, outputs are driven combinationally from the owner's live inputs:
  - c_addr = owner address.
  - c_read = owner read.
  - c_write = d_write for D, 0 otherwise.
  - c_wdata = d_wdata for D, 0 otherwise.
- Outside OWN states: c_read = c_write = 0, c_addr = 0, c_wdata = 0.
- When c_resp is asserted in OWN_x:
  - x_resp = 1 in that same cycle (combinational); line_rdata = c_rdata.
  - Next state is DONE.
  - No other resp is ever asserted; at most one resp bit is high per cycle.
- DONE: all c_* requests are 0; the next state is unconditionally IDLE.
- If the owner drops its request in OWN_x before c_resp (protocol violation):
  - State is held.
  - c_read/c_write follow the input and fall to 0.
  - The transaction is ended only by c_resp.
- PF transactions are not preempted. A D or I request arriving during OWN_PF waits until DONE -> IDLE.
- If D asserts both d_read and d_write, the write is honored; c_read is forced to 0 for D when d_write = 1.
- Reset values:
  - State IDLE, starve_cnt 0, owner 0, busy 0.
  - All resp bits 0; c_read, c_write 0.
  - c_addr, c_wdata 0; line_rdata follows c_rdata.
- Reset mid-transaction: the next state is IDLE with c_read/c_write 0 and no resp issued. The adaptor is reset by the same rst.

Test Plan:
- Single I read: i_read=1, i_addr=0x0000_0060, c_resp returned 4 cycles after c_read rises -> c_addr=0x60, c_read=1, owner=1; i_resp high exactly 1 cycle together with c_resp; line_rdata=c_rdata; idle gap seen before the next grant.
- Simultaneous D write + I read + PF read: d_addr=0x100, i_addr=0x200, pf_addr=0x220 -> grant order D (c_write=1, c_wdata=d_wdata), then I, then PF; each resp appears only on its owner.
- Starvation: d_read held continuously, i_read held, STARVE_LIMIT=4 -> four D grants, fifth grant goes to I, then starve_cnt=0.
- Prefetch in flight: PF owns, d_read rises mid-transaction -> no change to c_addr until PF c_resp; D granted 2 cycles after pf_resp (DONE, IDLE).
- PF_ENABLE=0: pf_read=1 for 20 cycles -> c_read stays 0, pf_resp never asserted, owner stays 0.
- Reset during OWN_D with c_write=1 -> c_write=0 and state IDLE next cycle, d_resp never asserted, starve_cnt=0.

Source files
------------

// File: rtl/pmem_req_scheduler.sv
// Arbitrates the single cacheline-adaptor line port among I-miss, D-miss and
// the stream-buffer prefetcher: one owner per transaction, D-first with I anti-starvation.
module pmem_req_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter bit PF_ENABLE    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  i_addr,
  input  logic         i_read,
  output logic         i_resp,
  input  logic [31:0]  d_addr,
  input  logic [255:0] d_wdata,
  input  logic         d_read,
  input  logic         d_write,
  output logic         d_resp,
  input  logic [31:0]  pf_addr,
  input  logic         pf_read,
  output logic         pf_resp,
  output logic [255:0] line_rdata,
  output logic [31:0]  c_addr,
  output logic [255:0] c_wdata,
  output logic         c_read,
  output logic         c_write,
  input  logic [255:0] c_rdata,
  input  logic         c_resp,
  output logic [1:0]   owner,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, OWN_I, OWN_D, OWN_PF, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       pf_req, d_req, i_forced;

  assign pf_req     = PF_ENABLE ? pf_read : 1'b0;
  assign d_req      = d_read | d_write;
  assign i_forced   = (starve_cnt == LIMIT) && i_read;
  assign line_rdata = c_rdata;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    c_addr     = 32'd0;
    c_wdata    = 256'd0;
    c_read     = 1'b0;
    c_write    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    pf_resp    = 1'b0;
    owner      = 2'd0;
    case (state)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_nxt  = OWN_D;
          starve_nxt = !i_read ? 4'd0 :
                       (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
        end else if (i_read) begin
          state_nxt  = OWN_I;
          starve_nxt = 4'd0;
        end else if (pf_req) begin
          state_nxt  = OWN_PF;
        end
      end
      // Owner inputs are passed through live; a dropped request just idles the
      // adaptor and only c_resp ends the transaction.
      OWN_I: begin
        owner  = 2'd1;
        c_addr = i_addr;
        c_read = i_read;
        if (c_resp) begin
          i_resp    = !rst;
          state_nxt = DONE;
        end
      end
      OWN_D: begin
        owner   = 2'd2;
        c_addr  = d_addr;
        c_wdata = d_wdata;
        c_write = d_write;
        c_read  = d_read & ~d_write;
        if (c_resp) begin
          d_resp    = !rst;
          state_nxt = DONE;
        end
      end
      OWN_PF: begin
        owner  = 2'd3;
        c_addr = pf_addr;
        c_read = pf_read;
        if (c_resp) begin
          pf_resp   = !rst;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pmem_req_scheduler.sv
// Bench for pmem_req_scheduler: directed scenarios plus a randomized run
// checked against a transaction-level ownership model.
module tb_pmem_req_scheduler;
  localparam int LIM = 4;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] i_addr = 0, d_addr = 0, pf_addr = 0;
  logic i_read = 0, d_read = 0, d_write = 0, pf_read = 0, c_resp = 0;
  logic [255:0] d_wdata = 0, c_rdata = 0;
  logic i_resp, d_resp, pf_resp, c_read, c_write, busy;
  logic [255:0] line_rdata, c_wdata;
  logic [31:0] c_addr;
  logic [1:0] owner;

  logic pf_read_n = 0, c_resp_n = 0;
  logic i_resp_n, d_resp_n, pf_resp_n, c_read_n, c_write_n, busy_n;
  logic [255:0] line_rdata_n, c_wdata_n;
  logic [31:0] c_addr_n;
  logic [1:0] owner_n;

  int total = 0, bad = 0;

  pmem_req_scheduler #(.STARVE_LIMIT(LIM), .PF_ENABLE(1'b1)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_read(i_read), .i_resp(i_resp),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_read(d_read), .d_write(d_write), .d_resp(d_resp),
    .pf_addr(pf_addr), .pf_read(pf_read), .pf_resp(pf_resp), .line_rdata(line_rdata),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_read(c_read), .c_write(c_write),
    .c_rdata(c_rdata), .c_resp(c_resp), .owner(owner), .busy(busy));

  pmem_req_scheduler #(.STARVE_LIMIT(LIM), .PF_ENABLE(1'b0)) dut_nopf (
    .clk(clk), .rst(rst), .i_addr(32'd0), .i_read(1'b0), .i_resp(i_resp_n),
    .d_addr(32'd0), .d_wdata(256'd0), .d_read(1'b0), .d_write(1'b0), .d_resp(d_resp_n),
    .pf_addr(32'h0000_0400), .pf_read(pf_read_n), .pf_resp(pf_resp_n), .line_rdata(line_rdata_n),
    .c_addr(c_addr_n), .c_wdata(c_wdata_n), .c_read(c_read_n), .c_write(c_write_n),
    .c_rdata(256'd0), .c_resp(c_resp_n), .owner(owner_n), .busy(busy_n));

  always #5 clk = ~clk;

  // Ownership model: 0 idle, 1 I, 2 D, 3 PF, 4 done; cnt counts D wins over a waiting I.
  int m_st = 0, m_cnt = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_cnt <= 0;
    end else if (m_st == 0) begin
      if ((d_read || d_write) && !(m_cnt == LIM && i_read)) begin
        m_st <= 2; m_cnt <= i_read ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
      end else if (i_read) begin
        m_st <= 1; m_cnt <= 0;
      end else if (pf_read) m_st <= 3;
    end else if (m_st == 4) m_st <= 0;
    else if (c_resp) m_st <= 4;
  end

  logic [1:0] e_owner;
  logic [31:0] e_caddr;
  logic [255:0] e_cwdata;
  logic e_cread, e_cwrite;
  logic [2:0] e_resp;
  always_comb begin
    e_owner = 2'd0; e_caddr = 32'd0; e_cwdata = 256'd0;
    e_cread = 1'b0; e_cwrite = 1'b0; e_resp = 3'b000;
    if (m_st == 1) begin
      e_owner = 2'd1; e_caddr = i_addr; e_cread = i_read;
      e_resp = (c_resp && !rst) ? 3'b100 : 3'b000;
    end else if (m_st == 2) begin
      e_owner = 2'd2; e_caddr = d_addr; e_cwrite = d_write; e_cwdata = d_wdata;
      e_cread = d_read && !d_write;
      e_resp = (c_resp && !rst) ? 3'b010 : 3'b000;
    end else if (m_st == 3) begin
      e_owner = 2'd3; e_caddr = pf_addr; e_cread = pf_read;
      e_resp = (c_resp && !rst) ? 3'b001 : 3'b000;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic clear_inputs();
    i_read = 0; d_read = 0; d_write = 0; pf_read = 0; c_resp = 0;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 0;
    for (int k = 0; k < 10; k++) begin
      if (owner != 2'd0) begin ok = 1; return; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); c_rdata = {8{$urandom}};
    tick(); #1;
    total++; if (owner !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_owner owner=%0d busy=%0b want 0/0", owner, busy); end
    total++; if ({c_read, c_write} !== 2'b00 || c_addr !== 32'd0 || c_wdata !== 256'd0) begin bad++; $display("FAIL reset_cport rd=%0b wr=%0b addr=%h want 0", c_read, c_write, c_addr); end
    total++; if ({i_resp, d_resp, pf_resp} !== 3'b000) begin bad++; $display("FAIL reset_resp got=%b want 000", {i_resp, d_resp, pf_resp}); end
    total++; if (line_rdata !== c_rdata) begin bad++; $display("FAIL reset_line got=%h want %h", line_rdata[31:0], c_rdata[31:0]); end
    rst = 0;
  endtask

  task automatic test_single_i();
    i_read = 1; i_addr = 32'h0000_0060;
    #1;
    total++; if (owner !== 2'd0 || c_read !== 1'b0) begin bad++; $display("FAIL single_no_same_cycle owner=%0d rd=%0b want 0/0", owner, c_read); end
    tick(); #1;
    total++; if (owner !== 2'd1 || c_addr !== 32'h60 || c_read !== 1'b1) begin bad++; $display("FAIL single_grant owner=%0d addr=%h rd=%0b want 1/60/1", owner, c_addr, c_read); end
    for (int k = 1; k < 4; k++) begin
      tick(); #1;
      total++; if (i_resp !== 1'b0 || c_read !== 1'b1) begin bad++; $display("FAIL single_wait cyc=%0d resp=%0b rd=%0b want 0/1", k, i_resp, c_read); end
    end
    tick(); c_resp = 1; c_rdata = {8{$urandom}}; #1;
    total++; if ({i_resp, d_resp, pf_resp} !== 3'b100 || line_rdata !== c_rdata) begin bad++; $display("FAIL single_resp got=%b want 100", {i_resp, d_resp, pf_resp}); end
    tick(); c_resp = 0; #1;
    total++; if (i_resp !== 1'b0 || owner !== 2'd0 || busy !== 1'b1 || c_read !== 1'b0) begin bad++; $display("FAIL single_done resp=%0b owner=%0d busy=%0b rd=%0b want 0/0/1/0", i_resp, owner, busy, c_read); end
    tick(); #1;
    total++; if (owner !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle_gap owner=%0d busy=%0b want 0/0", owner, busy); end
    i_read = 0; tick();
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [255:0] wd;
    wd = {8{$urandom}};
    d_write = 1; d_addr = 32'h100; d_wdata = wd;
    i_read = 1; i_addr = 32'h200; pf_read = 1; pf_addr = 32'h220;
    tick(); #1;
    total++; if (owner !== 2'd2 || c_write !== 1'b1 || c_read !== 1'b0 || c_addr !== 32'h100 || c_wdata !== wd) begin bad++; $display("FAIL simul_d owner=%0d wr=%0b rd=%0b addr=%h want 2/1/0/100", owner, c_write, c_read, c_addr); end
    c_resp = 1; #1;
    total++; if ({i_resp, d_resp, pf_resp} !== 3'b010) begin bad++; $display("FAIL simul_d_resp got=%b want 010", {i_resp, d_resp, pf_resp}); end
    tick(); c_resp = 0; d_write = 0;
    wait_grant(ok); #1;
    total++; if (!ok || owner !== 2'd1 || c_addr !== 32'h200) begin bad++; $display("FAIL simul_i owner=%0d addr=%h want 1/200", owner, c_addr); end
    c_resp = 1; #1;
    total++; if ({i_resp, d_resp, pf_resp} !== 3'b100) begin bad++; $display("FAIL simul_i_resp got=%b want 100", {i_resp, d_resp, pf_resp}); end
    tick(); c_resp = 0; i_read = 0;
    wait_grant(ok); #1;
    total++; if (!ok || owner !== 2'd3 || c_addr !== 32'h220 || c_read !== 1'b1) begin bad++; $display("FAIL simul_pf owner=%0d addr=%h want 3/220", owner, c_addr); end
    c_resp = 1; #1;
    total++; if ({i_resp, d_resp, pf_resp} !== 3'b001) begin bad++; $display("FAIL simul_pf_resp got=%b want 001", {i_resp, d_resp, pf_resp}); end
    tick(); c_resp = 0; pf_read = 0; tick();
  endtask

  task automatic test_starvation();
    bit ok;
    d_read = 1; d_addr = 32'h300; i_read = 1; i_addr = 32'h380;
    for (int g = 0; g <= LIM; g++) begin
      wait_grant(ok); #1;
      total++; if (!ok || owner !== ((g < LIM) ? 2'd2 : 2'd1)) begin bad++; $display("FAIL starve_grant n=%0d owner=%0d want %0d", g, owner, (g < LIM) ? 2 : 1); end
      c_resp = 1; tick(); c_resp = 0;
      if (g == LIM) i_read = 0;
    end
    #1;
    total++; if (dut.starve_cnt !== 4'd0) begin bad++; $display("FAIL starve_clear cnt=%0d want 0", dut.starve_cnt); end
    d_read = 0; tick(); tick();
  endtask

  task automatic test_pf_inflight();
    bit ok;
    pf_read = 1; pf_addr = 32'h340;
    wait_grant(ok); #1;
    total++; if (!ok || owner !== 2'd3) begin bad++; $display("FAIL pf_grant owner=%0d want 3", owner); end
    tick(); d_read = 1; d_addr = 32'h500;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (c_addr !== 32'h340 || owner !== 2'd3) begin bad++; $display("FAIL pf_hold cyc=%0d addr=%h owner=%0d want 340/3", k, c_addr, owner); end
      tick();
    end
    c_resp = 1; #1;
    total++; if ({i_resp, d_resp, pf_resp} !== 3'b001) begin bad++; $display("FAIL pf_resp got=%b want 001", {i_resp, d_resp, pf_resp}); end
    tick(); c_resp = 0; pf_read = 0; #1;
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL pf_done owner=%0d want 0", owner); end
    tick(); #1;
    total++; if (owner !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL pf_idle owner=%0d busy=%0b want 0/0", owner, busy); end
    tick(); #1;
    total++; if (owner !== 2'd2 || c_addr !== 32'h500) begin bad++; $display("FAIL pf_then_d owner=%0d addr=%h want 2/500", owner, c_addr); end
    c_resp = 1; tick(); c_resp = 0; d_read = 0; tick(); tick();
  endtask

  task automatic test_pf_disable();
    pf_read_n = 1;
    for (int k = 0; k < 20; k++) begin
      c_resp_n = 1'($urandom);
      #1;
      total++; if (c_read_n !== 1'b0 || pf_resp_n !== 1'b0 || owner_n !== 2'd0 || busy_n !== 1'b0) begin bad++; $display("FAIL pf_disabled cyc=%0d rd=%0b resp=%0b owner=%0d busy=%0b want 0", k, c_read_n, pf_resp_n, owner_n, busy_n); end
      tick();
    end
    pf_read_n = 0; c_resp_n = 0;
  endtask

  task automatic test_reset_mid();
    d_write = 1; d_addr = 32'h700; d_wdata = {8{$urandom}}; i_read = 1; i_addr = 32'h780;
    tick(); #1;
    total++; if (owner !== 2'd2 || c_write !== 1'b1) begin bad++; $display("FAIL rstmid_own owner=%0d wr=%0b want 2/1", owner, c_write); end
    rst = 1; c_resp = 1; #1;
    total++; if (d_resp !== 1'b0) begin bad++; $display("FAIL rstmid_no_resp got=%0b want 0", d_resp); end
    tick(); rst = 0; c_resp = 0; #1;
    total++; if (c_write !== 1'b0 || busy !== 1'b0 || owner !== 2'd0 || d_resp !== 1'b0) begin bad++; $display("FAIL rstmid_after wr=%0b busy=%0b owner=%0d resp=%0b want 0", c_write, busy, owner, d_resp); end
    total++; if (dut.starve_cnt !== 4'd0) begin bad++; $display("FAIL rstmid_cnt cnt=%0d want 0", dut.starve_cnt); end
    clear_inputs(); tick();
  endtask

  task automatic test_random();
    int own_cnt = 0, lat = 0, drop = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (drop == 1) i_read = 0;
      else if (!i_read && $urandom_range(0, 2) == 0) begin i_read = 1; i_addr = $urandom & 32'hFFFF_FFE0; end
      if (drop == 2) begin d_read = 0; d_write = 0; end
      else if (!d_read && !d_write && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: d_read = 1;
          1: d_write = 1;
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_addr = $urandom & 32'hFFFF_FFE0; d_wdata = {8{$urandom}};
      end
      if (drop == 3) pf_read = 0;
      else if (!pf_read && $urandom_range(0, 3) == 0) begin pf_read = 1; pf_addr = $urandom & 32'hFFFF_FFE0; end
      if (m_st >= 1 && m_st <= 3) own_cnt++;
      else begin own_cnt = 0; lat = $urandom_range(1, 4); end
      c_resp = (m_st >= 1 && m_st <= 3 && own_cnt >= lat);
      c_rdata = {8{$urandom}};
      drop = c_resp ? m_st : 0;
      #1;
      total++; if (owner !== e_owner || busy !== (m_st != 0)) begin bad++; $display("FAIL rnd_owner cyc=%0d owner=%0d busy=%0b want %0d/%0b", cyc, owner, busy, e_owner, m_st != 0); end
      total++; if (c_addr !== e_caddr || c_read !== e_cread || c_write !== e_cwrite) begin bad++; $display("FAIL rnd_cport cyc=%0d addr=%h rd=%0b wr=%0b want %h/%0b/%0b", cyc, c_addr, c_read, c_write, e_caddr, e_cread, e_cwrite); end
      total++; if (c_wdata !== e_cwdata) begin bad++; $display("FAIL rnd_wdata cyc=%0d got=%h want %h", cyc, c_wdata[31:0], e_cwdata[31:0]); end
      total++; if ({i_resp, d_resp, pf_resp} !== e_resp || line_rdata !== c_rdata) begin bad++; $display("FAIL rnd_resp cyc=%0d got=%b want %b", cyc, {i_resp, d_resp, pf_resp}, e_resp); end
      total++; if (dut.starve_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL rnd_starve cyc=%0d got=%0d want %0d", cyc, dut.starve_cnt, m_cnt); end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    tick();
    test_reset();
    test_single_i();
    test_simultaneous();
    test_starvation();
    test_pf_inflight();
    test_pf_disable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
